// File: rtl/bf_prog_loader.sv
// TinyBF serial program loader: parses sync/length/payload/checksum frames from the
// UART byte stream, writes program memory and answers with a one-byte ACK or NAK.
module bf_prog_loader #(
  parameter int          ADDR_W         = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              cpu_busy_i,
  output logic              prog_we_o,
  output logic [ADDR_W-1:0] prog_waddr_o,
  output logic [7:0]        prog_wdata_o,
  output logic              ack_valid_o,
  output logic [7:0]        ack_data_o,
  input  logic              ack_ready_i,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int         IDX_W     = ADDR_W + 1;
  localparam int         TMO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] MAX_LEN   = 9'(1 << ADDR_W);
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RESP = 3'd4
  } state_t;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               ack_valid_q, ack_valid_d;
  logic [7:0]         ack_data_q, ack_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Frame parser: next state, datapath updates and next registered outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ack_data_d = ack_data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = {TMO_W{1'b0}};
        if (rx_valid_i && (rx_data_i == SYNC_BYTE) && !cpu_busy_i) begin
          state_d = S_LEN;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        if (rx_valid_i) begin
          tmo_d = {TMO_W{1'b0}};
          if (state_q == S_LEN) begin
            if (({1'b0, rx_data_i} >= 9'd1) && ({1'b0, rx_data_i} <= MAX_LEN)) begin
              len_d   = IDX_W'(rx_data_i);
              csum_d  = rx_data_i;
              state_d = S_DATA;
            end else begin
              state_d    = S_RESP;
              ack_data_d = NAK_BYTE;
              err_d      = 1'b1;
            end
          end else if (state_q == S_DATA) begin
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = rx_data_i;
            csum_d  = csum_update(csum_q, rx_data_i);
            idx_d   = idx_q + IDX_W'(1);
            if ((idx_q + IDX_W'(1)) == len_q) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_RESP;
            if (rx_data_i == csum_q) begin
              ack_data_d = ACK_BYTE;
              done_d     = 1'b1;
            end else begin
              ack_data_d = NAK_BYTE;
              err_d      = 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // A byte in the timeout cycle takes the branch above, so it always wins.
          state_d    = S_RESP;
          ack_data_d = NAK_BYTE;
          err_d      = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        tmo_d = {TMO_W{1'b0}};
        if (ack_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= {IDX_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      csum_q      <= 8'h00;
      tmo_q       <= {TMO_W{1'b0}};
      we_q        <= 1'b0;
      waddr_q     <= {ADDR_W{1'b0}};
      wdata_q     <= 8'h00;
      ack_valid_q <= 1'b0;
      ack_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ack_valid_q <= ack_valid_d;
      ack_data_q  <= ack_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign prog_we_o    = we_q;
  assign prog_waddr_o = waddr_q;
  assign prog_wdata_o = wdata_q;
  assign ack_valid_o  = ack_valid_q;
  assign ack_data_o   = ack_data_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;

endmodule
